// File: rtl/burst_addr_gen.sv
// burst_addr_gen
//   Datapath/counter stage that sits behind the burst controller. It captures
//   the burst length and start address, counts completed beats, steps the
//   burst address, and raises stop_signal back to the controller once the
//   burst is exhausted. It also provides the single/burst address mux that
//   feeds the address PTS stage.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   burst_len_in/wen  : burst length capture (LEN_W bits)
//   initial_addr_in/wen : burst start address capture (ADDR_W bits)
//   counter_en        : one pulse per completed beat
//   adder_en          : qualifies the address increment on a beat
//   addr_sel          : 0 -> single_addr_in, 1 -> burst address
//   single_addr_in    : single-transfer address
//   addr_out          : muxed address (combinational)
//   beat_count        : beats completed in the current burst
//   stop_signal       : registered, high while the burst is complete
//   burst_active      : high while armed or running
//   addr_wrap         : sticky, an increment wrapped past the top address
//   len_err           : one-cycle pulse after a zero length is captured
module burst_addr_gen #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned LEN_W     = 4,
   parameter int unsigned ADDR_STEP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LEN_W-1:0]  burst_len_in,
   input  logic              burst_len_wen,
   input  logic [ADDR_W-1:0] initial_addr_in,
   input  logic              initial_addr_wen,
   input  logic              counter_en,
   input  logic              adder_en,
   input  logic              addr_sel,
   input  logic [ADDR_W-1:0] single_addr_in,
   output logic [ADDR_W-1:0] addr_out,
   output logic [LEN_W-1:0]  beat_count,
   output logic              stop_signal,
   output logic              burst_active,
   output logic              addr_wrap,
   output logic              len_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(ADDR_STEP);

   logic [1:0]        state;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  len_reg;
   logic              len_valid;
   logic              addr_valid;

   logic              any_wen;
   logic              len_valid_nxt;
   logic              addr_valid_nxt;
   logic [LEN_W-1:0]  len_nxt;
   logic              beat_acc;
   logic              final_beat;
   logic [LEN_W:0]    beat_inc;
   logic [ADDR_W:0]   addr_inc;

   // Flags and length as they will be after this edge, so a capture can
   // decide ARMED vs DONE in the same cycle it writes the registers.
   assign any_wen        = burst_len_wen | initial_addr_wen;
   assign len_valid_nxt  = len_valid  | burst_len_wen;
   assign addr_valid_nxt = addr_valid | initial_addr_wen;
   assign len_nxt        = burst_len_wen ? burst_len_in : len_reg;

   // A capture outranks a beat arriving in the same cycle.
   assign beat_acc   = counter_en & ~any_wen & ((state == S_ARMED) | (state == S_RUN));
   assign beat_inc   = {1'b0, beat_count} + (LEN_W+1)'(1);
   assign final_beat = (beat_inc == {1'b0, len_reg});

   // Extra MSB is the wrap carry.
   assign addr_inc = {1'b0, cur_addr} + STEP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cur_addr    <= '0;
         len_reg     <= '0;
         len_valid   <= 1'b0;
         addr_valid  <= 1'b0;
         beat_count  <= '0;
         stop_signal <= 1'b0;
         addr_wrap   <= 1'b0;
         len_err     <= 1'b0;
      end else begin
         len_err <= burst_len_wen & (burst_len_in == '0);
         if (any_wen) begin
            if (burst_len_wen) begin
               len_reg   <= burst_len_in;
               len_valid <= 1'b1;
            end
            if (initial_addr_wen) begin
               cur_addr   <= initial_addr_in;
               addr_valid <= 1'b1;
               addr_wrap  <= 1'b0;
            end
            beat_count <= '0;
            if (len_valid_nxt && addr_valid_nxt) begin
               // Zero length: nothing to transfer, report done immediately.
               if (len_nxt == '0) begin
                  state       <= S_DONE;
                  stop_signal <= 1'b1;
               end else begin
                  state       <= S_ARMED;
                  stop_signal <= 1'b0;
               end
            end else begin
               state       <= S_IDLE;
               stop_signal <= 1'b0;
            end
         end else if (beat_acc) begin
            beat_count <= beat_inc[LEN_W-1:0];
            if (final_beat) begin
               // Address stays on the last-beat value.
               state       <= S_DONE;
               stop_signal <= 1'b1;
            end else begin
               state <= S_RUN;
               if (adder_en) begin
                  cur_addr <= addr_inc[ADDR_W-1:0];
                  if (addr_inc[ADDR_W])
                     addr_wrap <= 1'b1;
               end
            end
         end
      end
   end

   assign burst_active = (state == S_ARMED) | (state == S_RUN);
   assign addr_out     = addr_sel ? cur_addr : single_addr_in;

endmodule

// File: tb/tb_burst_addr_gen.sv
// Testbench for burst_addr_gen: directed scenarios with fixed expected
// values, then a randomized run checked against a behavioural model.
module tb_burst_addr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  burst_len_in;
   logic        burst_len_wen;
   logic [15:0] initial_addr_in;
   logic        initial_addr_wen;
   logic        counter_en;
   logic        adder_en;
   logic        addr_sel;
   logic [15:0] single_addr_in;
   logic [15:0] addr_out;
   logic [3:0]  beat_count;
   logic        stop_signal;
   logic        burst_active;
   logic        addr_wrap;
   logic        len_err;

   int checks = 0;
   int errors = 0;

   // Behavioural model: burst described by its length, beats done,
   // current address and whether it is still accepting beats.
   bit m_lv, m_av, m_active, m_stop, m_wrap, m_err;
   int m_len, m_beats, m_addr;

   burst_addr_gen dut (
      .clk(clk), .rst(rst),
      .burst_len_in(burst_len_in), .burst_len_wen(burst_len_wen),
      .initial_addr_in(initial_addr_in), .initial_addr_wen(initial_addr_wen),
      .counter_en(counter_en), .adder_en(adder_en), .addr_sel(addr_sel),
      .single_addr_in(single_addr_in), .addr_out(addr_out),
      .beat_count(beat_count), .stop_signal(stop_signal),
      .burst_active(burst_active), .addr_wrap(addr_wrap), .len_err(len_err)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      if (rst) begin
         m_lv = 0; m_av = 0; m_active = 0; m_stop = 0; m_wrap = 0; m_err = 0;
         m_len = 0; m_beats = 0; m_addr = 0;
      end else begin
         m_err = burst_len_wen && (burst_len_in == 0);
         if (burst_len_wen || initial_addr_wen) begin
            if (burst_len_wen) begin m_len = burst_len_in; m_lv = 1; end
            if (initial_addr_wen) begin m_addr = initial_addr_in; m_av = 1; m_wrap = 0; end
            m_beats  = 0;
            m_active = m_lv && m_av && (m_len != 0);
            m_stop   = m_lv && m_av && (m_len == 0);
         end else if (counter_en && m_active) begin
            m_beats++;
            if (m_beats == m_len) begin
               m_active = 0;
               m_stop   = 1;
            end else if (adder_en) begin
               m_addr = m_addr + 1;
               if (m_addr > 16'hFFFF) begin
                  m_addr = m_addr - 65536;
                  m_wrap = 1;
               end
            end
         end
      end
   endtask

   // One clock: inputs already driven are sampled at the edge, the model
   // advances, then single-cycle strobes are dropped.
   task automatic step();
      @(posedge clk);
      #1;
      model_update();
      burst_len_wen    = 0;
      initial_addr_wen = 0;
      counter_en       = 0;
      rst              = 0;
   endtask

   task automatic load(input logic [3:0] len, input logic [15:0] addr);
      burst_len_in = len; initial_addr_in = addr;
      burst_len_wen = 1; initial_addr_wen = 1;
      step();
   endtask

   task automatic pulse(input int gap);
      counter_en = 1;
      step();
      for (int i = 0; i < gap; i++) step();
   endtask

   task automatic test_reset();
      rst = 1; addr_sel = 0; single_addr_in = 16'h5555;
      step();
      checks++; if (addr_out !== 16'h5555) begin errors++; $display("FAIL reset_addr_out got %h want 5555", addr_out); end
      checks++; if (beat_count !== 4'd0) begin errors++; $display("FAIL reset_beat got %0d want 0", beat_count); end
      checks++; if ({stop_signal, burst_active, addr_wrap, len_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {stop_signal, burst_active, addr_wrap, len_err});
      end
   endtask

   task automatic test_basic_burst();
      logic [15:0] exp_a;
      adder_en = 1; addr_sel = 1;
      load(4'd4, 16'h1230);
      checks++; if (addr_out !== 16'h1230 || burst_active !== 1'b1) begin
         errors++; $display("FAIL basic_load got %h/%b want 1230/1", addr_out, burst_active);
      end
      for (int k = 0; k < 4; k++) begin
         counter_en = 1;
         step();
         exp_a = 16'h1230 + 16'((k < 3) ? k + 1 : 3);
         checks++; if (addr_out !== exp_a) begin errors++; $display("FAIL basic_addr%0d got %h want %h", k, addr_out, exp_a); end
         checks++; if (stop_signal !== (k == 3) || burst_active !== (k != 3)) begin
            errors++; $display("FAIL basic_stop%0d got stop %b active %b", k, stop_signal, burst_active);
         end
         step(); step();
      end
      checks++; if (beat_count !== 4'd4 || addr_out !== 16'h1233 || stop_signal !== 1'b1) begin
         errors++; $display("FAIL basic_hold got beat %0d addr %h stop %b want 4 1233 1", beat_count, addr_out, stop_signal);
      end
   endtask

   task automatic test_wrap();
      load(4'd3, 16'hFFFE);
      pulse(1);
      checks++; if (addr_out !== 16'hFFFF || addr_wrap !== 1'b0) begin errors++; $display("FAIL wrap_p1 got %h %b want ffff 0", addr_out, addr_wrap); end
      pulse(1);
      checks++; if (addr_out !== 16'h0000 || addr_wrap !== 1'b1 || stop_signal !== 1'b0) begin
         errors++; $display("FAIL wrap_p2 got %h wrap %b stop %b want 0000 1 0", addr_out, addr_wrap, stop_signal);
      end
      pulse(1);
      checks++; if (addr_out !== 16'h0000 || stop_signal !== 1'b1) begin errors++; $display("FAIL wrap_p3 got %h stop %b want 0000 1", addr_out, stop_signal); end
   endtask

   task automatic test_zero_len();
      burst_len_in = 0; burst_len_wen = 1;
      step();
      checks++; if (len_err !== 1'b1 || stop_signal !== 1'b1 || burst_active !== 1'b0) begin
         errors++; $display("FAIL zero_first got err %b stop %b active %b want 1 1 0", len_err, stop_signal, burst_active);
      end
      step();
      checks++; if (len_err !== 1'b0 || stop_signal !== 1'b1) begin errors++; $display("FAIL zero_pulse got err %b stop %b want 0 1", len_err, stop_signal); end
      for (int i = 0; i < 5; i++) pulse(0);
      checks++; if (beat_count !== 4'd0 || addr_out !== 16'h0000) begin
         errors++; $display("FAIL zero_ignore got beat %0d addr %h want 0 0000", beat_count, addr_out);
      end
   endtask

   task automatic test_adder_hold();
      load(4'd5, 16'h0040);
      adder_en = 1; pulse(1);
      checks++; if (addr_out !== 16'h0041) begin errors++; $display("FAIL hold_p1 got %h want 0041", addr_out); end
      adder_en = 0; pulse(1);
      checks++; if (addr_out !== 16'h0041) begin errors++; $display("FAIL hold_p2 got %h want 0041", addr_out); end
      adder_en = 1; pulse(1);
      checks++; if (addr_out !== 16'h0042 || beat_count !== 4'd3) begin
         errors++; $display("FAIL hold_p3 got %h beat %0d want 0042 3", addr_out, beat_count);
      end
   endtask

   task automatic test_back_to_back();
      load(4'd5, 16'h0200);
      pulse(0); pulse(0);
      initial_addr_in = 16'h0100; initial_addr_wen = 1; counter_en = 1;
      step();
      checks++; if (beat_count !== 4'd0 || addr_out !== 16'h0100 || stop_signal !== 1'b0 || burst_active !== 1'b1) begin
         errors++; $display("FAIL recap got beat %0d addr %h stop %b active %b", beat_count, addr_out, stop_signal, burst_active);
      end
      for (int i = 0; i < 4; i++) pulse(0);
      checks++; if (addr_out !== 16'h0104 || stop_signal !== 1'b0) begin errors++; $display("FAIL recap_p4 got %h stop %b want 0104 0", addr_out, stop_signal); end
      pulse(0);
      checks++; if (addr_out !== 16'h0104 || stop_signal !== 1'b1 || beat_count !== 4'd5) begin
         errors++; $display("FAIL recap_done got %h stop %b beat %0d want 0104 1 5", addr_out, stop_signal, beat_count);
      end
   endtask

   task automatic test_mid_reset();
      load(4'd5, 16'h0300);
      pulse(0); pulse(0);
      rst = 1; addr_sel = 0; single_addr_in = 16'hABCD;
      step();
      checks++; if (addr_out !== 16'hABCD || beat_count !== 4'd0 || {stop_signal, burst_active, addr_wrap, len_err} !== 4'b0000) begin
         errors++; $display("FAIL mrst got addr %h beat %0d flags %b", addr_out, beat_count, {stop_signal, burst_active, addr_wrap, len_err});
      end
      for (int i = 0; i < 3; i++) pulse(0);
      checks++; if (beat_count !== 4'd0 || stop_signal !== 1'b0 || burst_active !== 1'b0) begin
         errors++; $display("FAIL mrst_idle got beat %0d stop %b active %b", beat_count, stop_signal, burst_active);
      end
      addr_sel = 1; #1;
      checks++; if (addr_out !== 16'h0000) begin errors++; $display("FAIL mrst_cur got %h want 0000", addr_out); end
   endtask

   task automatic test_random();
      logic [15:0] exp_a;
      rst = 1; step();
      for (int n = 0; n < 600; n++) begin
         rst              = ($urandom_range(0, 79) == 0);
         burst_len_wen    = ($urandom_range(0, 9) == 0);
         initial_addr_wen = ($urandom_range(0, 9) == 0);
         burst_len_in     = 4'($urandom_range(0, 6));
         initial_addr_in  = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFF - $urandom_range(0, 4)) : 16'($urandom);
         counter_en       = ($urandom_range(0, 1) == 1);
         adder_en         = ($urandom_range(0, 3) != 0);
         addr_sel         = ($urandom_range(0, 3) != 0);
         single_addr_in   = 16'($urandom);
         step();
         exp_a = addr_sel ? 16'(m_addr) : single_addr_in;
         checks++; if (addr_out !== exp_a) begin errors++; $display("FAIL rnd_addr@%0d got %h want %h", n, addr_out, exp_a); end
         checks++; if (beat_count !== 4'(m_beats)) begin errors++; $display("FAIL rnd_beat@%0d got %0d want %0d", n, beat_count, m_beats); end
         checks++; if ({stop_signal, burst_active, addr_wrap, len_err} !== {m_stop, m_active, m_wrap, m_err}) begin
            errors++; $display("FAIL rnd_flags@%0d got %b want %b", n, {stop_signal, burst_active, addr_wrap, len_err}, {m_stop, m_active, m_wrap, m_err});
         end
      end
   endtask

   initial begin
      rst = 0; burst_len_in = 0; burst_len_wen = 0; initial_addr_in = 0;
      initial_addr_wen = 0; counter_en = 0; adder_en = 0; addr_sel = 0; single_addr_in = 0;
      test_reset();
      test_basic_burst();
      test_wrap();
      test_zero_len();
      test_adder_hold();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_addr_gen.md
Name: burst_addr_gen

Overview:
- Datapath/counter stage directly downstream of the burst controller. It consumes the controller's load strobes, counter_en, adder_en and addr_sel.
- Holds the captured burst length and initial address, counts completed beats, and generates the incrementing burst address.
- Asserts stop_signal back to the controller when the burst is exhausted.
- Provides the single/burst address mux that feeds the address PTS stage.

Parameters:
- ADDR_W, 16, address width in bits.
- LEN_W, 4, burst-length and beat-counter width in bits.
- ADDR_STEP, 1, address increment per beat; added modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- burst_len_in  in  LEN_W  parallel burst length from the burst-length STP.
- burst_len_wen  in  1  capture burst_len_in (the controller's initial_burst_len_reg_en).
- initial_addr_in  in  ADDR_W  parallel start address from the address STP.
- initial_addr_wen  in  1  capture initial_addr_in (the controller's initial_addr_reg_wen).
- counter_en  in  1  one-cycle pulse marking completion of one beat.
- adder_en  in  1  level; qualifies address increment.
- addr_sel  in  1  0 selects single_addr_in, 1 selects the burst address.
- single_addr_in  in  ADDR_W  single-transfer address.
- addr_out  out  ADDR_W  combinational mux: addr_sel ? cur_addr : single_addr_in.
- beat_count  out  LEN_W  completed beats in the current burst.
- stop_signal  out  1  registered; high while the burst is complete.
- burst_active  out  1  high in ARMED or RUN.
- addr_wrap  out  1  sticky; set when an increment wraps past 2^ADDR_W-1.
- len_err  out  1  one-cycle pulse when a length of 0 is captured.

Behaviour:
- Reset is synchronous: on the rising edge with rst=1, all registers clear.
  - cur_addr=0, len_reg=0, beat_count=0, both valid flags=0.
  - stop_signal=0, addr_wrap=0, len_err=0.
  - state=IDLE, so burst_active=0.
  - addr_out follows the mux (single_addr_in at reset with addr_sel=0).
  - rst mid-burst aborts the burst immediately; no partial state survives.
- Capture:
  - burst_len_wen: len_reg<=burst_len_in, len_valid<=1.
  - initial_addr_wen: cur_addr<=initial_addr_in, addr_valid<=1, addr_wrap<=0.
  - Either wen also sets beat_count<=0 and stop_signal<=0.
  - Both wens in the same cycle: both capture.
  - Valid flags stay set until rst.
  - Capture has priority: a counter_en in the same cycle as any wen is ignored.
- FSM states: IDLE, ARMED, RUN, DONE.
  - IDLE: waits for both valid flags. Go to ARMED on the cycle after both are set; if the captured length is 0, go to DONE instead.
  - ARMED: go to RUN on the first accepted counter_en.
  - RUN: beats in progress.
  - DONE: stop_signal=1. counter_en and adder_en are ignored. Exit only on a new capture, which re-enters ARMED (or DONE if the length is 0), or on rst.
  - Any wen in ARMED, RUN or DONE returns the FSM to ARMED with the count cleared.
- Beat accept: counter_en=1 in ARMED/RUN with no wen that cycle.
  - beat_count<=beat_count+1.
  - If this is not the final beat (beat_count+1 < len_reg) and adder_en=1: cur_addr<=cur_addr+ADDR_STEP, wrapping mod 2^ADDR_W. A wrap sets addr_wrap.
  - If adder_en=0: the beat is counted but the address is held.
  - Final beat (beat_count+1 == len_reg): cur_addr is held at the last-beat address, stop_signal<=1, state<=DONE.
  - stop_signal is visible on the cycle after the final counter_en pulse.
- Length semantics: len_reg=N means N beats, N in 1..2^LEN_W-1.
  - N=0: len_err pulses for 1 cycle on the cycle after capture.
  - N=0: the FSM goes straight to DONE and stop_signal=1 on that same cycle; no beats are accepted.
- Addresses of an N-beat burst: start, start+STEP, ..., start+(N-1)*STEP.
- counter_en held high for multiple cycles counts one beat per cycle.
- addr_sel has no effect on counting; it only switches the mux.

Test Plan:
1. Load len=4 and addr=0x1230 together, adder_en=1, addr_sel=1, then 4 counter_en pulses 3 cycles apart -> addr_out 0x1230,0x1231,0x1232,0x1233, held after the 4th pulse; beat_count=4; stop_signal rises 1 cycle after the 4th pulse; burst_active falls on that same cycle.
2. addr=0xFFFE, len=3, 3 pulses -> addr_out 0xFFFE,0xFFFF,0x0000; addr_wrap=1 after the 2nd pulse; stop_signal=1 after the 3rd.
3. len=0 with a valid addr -> len_err high exactly 1 cycle and stop_signal=1 on that same cycle; 5 further counter_en pulses leave beat_count=0 and the address unchanged.
4. len=5, addr=0x0040, pulses with adder_en 1,0,1 -> addr_out 0x0041 after pulse 1, still 0x0041 after pulse 2, 0x0042 after pulse 3; beat_count=3.
5. len=5 after 2 beats: initial_addr_wen with 0x0100 in the same cycle as counter_en -> beat_count=0, cur_addr=0x0100, stop_signal=0, state ARMED; 5 more pulses complete the burst with the retained len=5.
6. rst=1 for 1 cycle mid-RUN (beat_count=2), then counter_en pulses before any capture -> all outputs at reset values and stop_signal=0; pulses are ignored in IDLE. With addr_sel=0, addr_out tracks single_addr_in=0xABCD.
